plic_claim_seq: RTL and testbench

PLIC_CLAIM_SEQ -- requirements
Module: plic_claim_seq

---
 rtl/plic_claim_seq.sv | 115 +++++++++++
 tb/tb_plic_claim_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_seq.sv
// rtl/plic_claim_seq.sv - PLIC claim/complete sequencer with software register-port arbitration
// The FSM owns the port during claim and complete; software gets every other cycle.
module plic_claim_seq #(
  parameter logic [23:0] CLAIM_ADDR = 24'h200004,
  parameter int          ID_W       = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            plic_notif,
  output logic            plic_wen,
  output logic            plic_ren,
  output logic [23:0]     plic_addr,
  output logic [31:0]     plic_wdata,
  input  logic [31:0]     plic_rdata,
  input  logic            sw_req,
  input  logic            sw_wen,
  input  logic [23:0]     sw_addr,
  input  logic [31:0]     sw_wdata,
  output logic            sw_gnt,
  output logic            sw_rvalid,
  output logic [31:0]     sw_rdata,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ready,
  input  logic            irq_done,
  output logic            irq_busy,
  output logic [7:0]      spur_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLAIM, S_CAPT, S_PRESENT, S_SERVICE, S_COMPL
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_spur;
  logic            r_sw_rd_pend;
  logic [31:0]     r_sw_rdata;
  logic            w_fsm_rd;
  logic            w_fsm_wr;
  logic            w_sw_gnt;
  logic            w_capt_zero;

  assign w_capt_zero = (plic_rdata[ID_W-1:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (plic_notif) w_next = S_CLAIM;
      S_CLAIM:   w_next = S_CAPT;
      S_CAPT:    w_next = w_capt_zero ? S_IDLE : S_PRESENT;
      S_PRESENT: if (irq_ready) w_next = S_SERVICE;
      S_SERVICE: if (irq_done) w_next = S_COMPL;
      S_COMPL:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_fsm_rd   = (r_state == S_CLAIM);
    w_fsm_wr   = (r_state == S_COMPL);
    irq_valid  = (r_state == S_PRESENT);
    irq_busy   = (r_state == S_CLAIM) || (r_state == S_CAPT) ||
                 (r_state == S_PRESENT) || (r_state == S_SERVICE);
    // rst gate keeps the grant low while reset is held, before any edge
    w_sw_gnt   = sw_req && !rst && !w_fsm_rd && !w_fsm_wr;
    plic_wen   = 1'b0;
    plic_ren   = 1'b0;
    plic_addr  = '0;
    plic_wdata = '0;
    if (w_fsm_rd) begin
      plic_ren  = 1'b1;
      plic_addr = CLAIM_ADDR;
    end else if (w_fsm_wr) begin
      plic_wen   = 1'b1;
      plic_addr  = CLAIM_ADDR;
      plic_wdata = {{(32-ID_W){1'b0}}, r_id};
    end else if (w_sw_gnt) begin
      plic_wen   = sw_wen;
      plic_ren   = !sw_wen;
      plic_addr  = sw_addr;
      plic_wdata = sw_wdata;
    end
  end

  // The pending flag tags the next-cycle return as software's; CAPT never sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id         <= '0;
      r_spur       <= '0;
      r_sw_rd_pend <= 1'b0;
      r_sw_rdata   <= '0;
    end else begin
      if (r_state == S_CAPT) begin
        r_id <= plic_rdata[ID_W-1:0];
        if (w_capt_zero && r_spur != 8'hFF) r_spur <= r_spur + 8'd1;
      end
      r_sw_rd_pend <= w_sw_gnt && !sw_wen;
      if (r_sw_rd_pend) r_sw_rdata <= plic_rdata;
    end
  end

  assign sw_gnt    = w_sw_gnt;
  assign sw_rvalid = r_sw_rd_pend;
  assign sw_rdata  = r_sw_rd_pend ? plic_rdata : r_sw_rdata;
  assign irq_id    = r_id;
  assign spur_cnt  = r_spur;

endmodule

// File: tb/tb_plic_claim_seq.sv
// tb/tb_plic_claim_seq.sv - self-checking bench for plic_claim_seq
// Directed vector table, hand-written corner sequences, then random traffic against a model.
module tb_plic_claim_seq;
  localparam logic [23:0] CA = 24'h200004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        plic_notif = 1'b0;
  logic        plic_wen, plic_ren;
  logic [23:0] plic_addr;
  logic [31:0] plic_wdata;
  logic [31:0] plic_rdata = '0;
  logic        sw_req = 1'b0, sw_wen = 1'b0;
  logic [23:0] sw_addr = '0;
  logic [31:0] sw_wdata = '0;
  logic        sw_gnt, sw_rvalid;
  logic [31:0] sw_rdata;
  logic        irq_valid;
  logic [6:0]  irq_id;
  logic        irq_ready = 1'b0, irq_done = 1'b0;
  logic        irq_busy;
  logic [7:0]  spur_cnt;

  int errs = 0;
  int checks = 0;

  plic_claim_seq #(.CLAIM_ADDR(CA), .ID_W(7)) dut (
    .clk(clk), .rst(rst), .plic_notif(plic_notif),
    .plic_wen(plic_wen), .plic_ren(plic_ren), .plic_addr(plic_addr),
    .plic_wdata(plic_wdata), .plic_rdata(plic_rdata),
    .sw_req(sw_req), .sw_wen(sw_wen), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .sw_gnt(sw_gnt), .sw_rvalid(sw_rvalid), .sw_rdata(sw_rdata),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready),
    .irq_done(irq_done), .irq_busy(irq_busy), .spur_cnt(spur_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    plic_notif = 0; sw_req = 0; sw_wen = 0; sw_addr = '0; sw_wdata = '0;
    irq_ready = 0; irq_done = 0; plic_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " port"}, {plic_wen, plic_ren, plic_addr, plic_wdata}, '0);
    chk({tag, " ctl"}, {sw_gnt, sw_rvalid, irq_valid, irq_id, irq_busy, spur_cnt}, '0);
    chk({tag, " sw_rdata"}, sw_rdata, '0);
  endtask

  typedef struct {
    logic        notif, sreq, swen, rdy, dn;
    logic [23:0] saddr;
    logic [31:0] swdata, rdata;
    logic        e_ren, e_wen;
    logic [23:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_valid;
    logic [6:0]  e_id;
    logic        e_busy, e_gnt, e_rvalid;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic n, sr, sw, rd, dn, input logic [23:0] sa,
                              input logic [31:0] swd, rdat, input logic er, ew,
                              input logic [23:0] ea, input logic [31:0] ewd,
                              input logic ev, input logic [6:0] eid,
                              input logic eb, eg, erv, input logic [31:0] erd);
    vec_t v;
    v.notif = n; v.sreq = sr; v.swen = sw; v.rdy = rd; v.dn = dn;
    v.saddr = sa; v.swdata = swd; v.rdata = rdat;
    v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_wdata = ewd;
    v.e_valid = ev; v.e_id = eid; v.e_busy = eb; v.e_gnt = eg; v.e_rvalid = erv;
    v.e_rdata = erd;
    return v;
  endfunction

  // Behavioural reference: claim/complete scheduled as cycle numbers, handler as two flags.
  int          m_cyc, m_claim_at, m_compl_at, m_spur;
  bit          m_offering, m_serving, m_rd_pend;
  logic [6:0]  m_id;
  logic [31:0] m_hold;

  task automatic model_reset();
    m_cyc = 0; m_claim_at = -10; m_compl_at = -10; m_spur = 0;
    m_offering = 0; m_serving = 0; m_rd_pend = 0; m_id = '0; m_hold = '0;
  endtask

  task automatic model_cycle();
    bit          fsm_rd, fsm_wr, capt, busy, idle, gnt;
    logic [57:0] e_port;
    logic [18:0] e_ctl;
    fsm_rd = (m_cyc == m_claim_at);
    fsm_wr = (m_cyc == m_compl_at);
    capt   = (m_cyc == m_claim_at + 1);
    busy   = fsm_rd || capt || m_offering || m_serving;
    idle   = !busy && !fsm_wr;
    gnt    = sw_req && !fsm_rd && !fsm_wr;
    if (fsm_rd)      e_port = {1'b0, 1'b1, CA, 32'h0};
    else if (fsm_wr) e_port = {1'b1, 1'b0, CA, 25'h0, m_id};
    else if (gnt)    e_port = {sw_wen, !sw_wen, sw_addr, sw_wdata};
    else             e_port = '0;
    e_ctl = {gnt, m_offering, (m_offering ? m_id : 7'h0), busy, m_rd_pend, m_spur[7:0]};
    chk("rand port", {6'h0, plic_wen, plic_ren, plic_addr, plic_wdata}, {6'h0, e_port});
    chk("rand ctl", {45'h0, sw_gnt, irq_valid, (irq_valid ? irq_id : 7'h0), irq_busy,
                     sw_rvalid, spur_cnt}, {45'h0, e_ctl});
    chk("rand sw_rdata", sw_rdata, m_rd_pend ? plic_rdata : m_hold);
    if (m_rd_pend) m_hold = plic_rdata;
    m_rd_pend = gnt && !sw_wen;
    if (capt) begin
      m_id = plic_rdata[6:0];
      if (m_id != 0) m_offering = 1;
      else if (m_spur < 255) m_spur++;
    end else if (m_offering && irq_ready) begin
      m_offering = 0; m_serving = 1;
    end else if (m_serving && irq_done) begin
      m_serving = 0; m_compl_at = m_cyc + 1;
    end
    if (idle && plic_notif) m_claim_at = m_cyc + 1;
    m_cyc++;
  endtask

  vec_t tv[13];

  initial begin
    int nrd, bad;
    bit pending;

    // Claim with a concurrent software read, PRESENT/irq_ready done-filtering, then complete.
    tv[0]  = mk(1,0,0,0,0, 24'h0, 32'h0, 32'h0,        0,0,24'h0, 32'h0,  0,7'h0,  0,0,0, 32'h0);
    tv[1]  = mk(0,1,0,0,0, 24'h4, 32'h0, 32'h0,        1,0,CA,    32'h0,  0,7'h0,  1,0,0, 32'h0);
    tv[2]  = mk(0,1,0,0,0, 24'h4, 32'h0, 32'hFFFFFF95, 1,0,24'h4, 32'h0,  0,7'h0,  1,1,0, 32'h0);
    tv[3]  = mk(0,0,0,0,1, 24'h0, 32'h0, 32'h12345678, 0,0,24'h0, 32'h0,  1,7'h15, 1,0,1, 32'h12345678);
    tv[4]  = mk(0,0,0,1,1, 24'h0, 32'h0, 32'h0,        0,0,24'h0, 32'h0,  1,7'h15, 1,0,0, 32'h12345678);
    for (int i = 5; i < 9; i++)
      tv[i] = mk(0,0,0,0,0, 24'h0, 32'h0, 32'h0,       0,0,24'h0, 32'h0,  0,7'h0,  1,0,0, 32'h12345678);
    tv[9]  = mk(0,0,0,0,1, 24'h0, 32'h0, 32'h0,        0,0,24'h0, 32'h0,  0,7'h0,  1,0,0, 32'h12345678);
    tv[10] = mk(0,1,1,0,0, 24'h10,32'hAA,32'h0,        0,1,CA,    32'h15, 0,7'h0,  0,0,0, 32'h12345678);
    tv[11] = mk(0,1,1,0,0, 24'h10,32'hAA,32'h0,        0,1,24'h10,32'hAA, 0,7'h0,  0,1,0, 32'h12345678);
    tv[12] = mk(0,0,0,0,0, 24'h0, 32'h0, 32'h0,        0,0,24'h0, 32'h0,  0,7'h0,  0,0,0, 32'h12345678);

    rst = 1; sw_req = 1; plic_notif = 1;
    #2;
    check_all_zero("reset");
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 13; i++) begin
      plic_notif = tv[i].notif; sw_req = tv[i].sreq; sw_wen = tv[i].swen;
      irq_ready = tv[i].rdy; irq_done = tv[i].dn; sw_addr = tv[i].saddr;
      sw_wdata = tv[i].swdata; plic_rdata = tv[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d port", i), {plic_ren, plic_wen, plic_addr, plic_wdata},
          {tv[i].e_ren, tv[i].e_wen, tv[i].e_addr, tv[i].e_wdata});
      chk($sformatf("vec%0d irq", i), {irq_valid, (irq_valid ? irq_id : 7'h0), irq_busy},
          {tv[i].e_valid, tv[i].e_id, tv[i].e_busy});
      chk($sformatf("vec%0d sw", i), {sw_gnt, sw_rvalid, sw_rdata},
          {tv[i].e_gnt, tv[i].e_rvalid, tv[i].e_rdata});
      @(posedge clk); #1;
    end
    clear_inputs();

    // Spurious claims: three, then up to 258 in total for saturation.
    nrd = 0; bad = 0;
    plic_notif = 1;
    for (int c = 0; c < 3000 && nrd < 3; c++) begin
      @(negedge clk);
      if (plic_ren) nrd++;
      if (irq_valid || plic_wen) bad++;
      @(posedge clk); #1;
    end
    plic_notif = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_cnt after 3", spur_cnt, 8'd3);
    plic_notif = 1;
    for (int c = 0; c < 3000 && nrd < 258; c++) begin
      @(negedge clk);
      if (plic_ren) nrd++;
      if (irq_valid || plic_wen) bad++;
      @(posedge clk); #1;
    end
    plic_notif = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("spurious claim count", nrd, 258);
    chk("spur_cnt saturated", spur_cnt, 8'd255);
    chk("no offer/complete on spurious", bad, 0);

    // Back-to-back software reads while idle.
    for (int k = 0; k <= 8; k++) begin
      sw_req = (k < 8); sw_wen = 0; sw_addr = 24'(k);
      plic_rdata = 32'hD0000000 + k;
      @(negedge clk);
      if (k < 8) chk($sformatf("b2b gnt%0d", k), {sw_gnt, plic_ren, plic_addr}, {1'b1, 1'b1, 24'(k)});
      if (k > 0) chk($sformatf("b2b ret%0d", k), {sw_rvalid, sw_rdata}, {1'b1, 32'hD0000000 + k});
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    chk("b2b no extra rvalid", sw_rvalid, 1'b0);
    @(posedge clk); #1;

    // Reset asserted mid-cycle while in SERVICE.
    plic_notif = 1;
    @(posedge clk); #1; plic_notif = 0;
    @(posedge clk); #1; plic_rdata = 32'h2A;
    @(posedge clk); #1; plic_rdata = 0; irq_ready = 1;
    @(posedge clk); #1; irq_ready = 0;
    #2;
    chk("service busy", {irq_busy, irq_valid}, 2'b10);
    rst = 1; sw_req = 1; irq_done = 1;
    #1;
    check_all_zero("mid reset");
    @(posedge clk); #3;
    rst = 0; sw_req = 0; irq_done = 0; plic_notif = 1;
    @(negedge clk);
    chk("post reset idle", {plic_ren, plic_wen}, 2'b00);
    @(posedge clk); #1;
    plic_notif = 0;
    @(negedge clk);
    chk("post reset claim", {plic_ren, plic_wen, plic_addr}, {1'b1, 1'b0, CA});
    repeat (3) @(posedge clk);
    #1;

    // Random traffic against the reference model.
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    pending = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!pending) begin
        sw_req   = ($urandom_range(0, 2) == 0);
        sw_wen   = $urandom_range(0, 1);
        sw_addr  = ($urandom_range(0, 7) == 0) ? CA : 24'($urandom);
        sw_wdata = $urandom;
      end
      plic_notif = ($urandom_range(0, 3) != 0);
      irq_ready  = $urandom_range(0, 1);
      irq_done   = ($urandom_range(0, 2) == 0);
      plic_rdata = $urandom;
      if ($urandom_range(0, 3) == 0) plic_rdata[6:0] = 7'h0;
      @(negedge clk);
      model_cycle();
      pending = sw_req && !sw_gnt;
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
